bcd_sum_display_ctrl: RTL

//  Sequencer for the 4-bit adder + 7-segment path. Captures operand A, then operand B,

---
 rtl/bcd_disp_pkg.sv | 41 ++++
 rtl/btn_debounce.sv | 50 +++++
 rtl/sum4bcc.sv | 23 ++
 rtl/bcd_sum_display_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD sum display controller.
//   state_e   : FSM state encodings (also exported on the debug LEDs)
//   SEG_BLANK : all segments off (active-low)
//   hex7seg   : 4-bit value to active-low 7-segment pattern, MSB = segment a, LSB = segment g
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_SHOW   = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex font: 0..9, A, b, C, d, E, F. Bit order {a,b,c,d,e,f,g}, 0 = segment lit.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchroniser, stability counter and rising-edge pulse.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   btn_in : raw asynchronous, bouncing button (active-high)
//   press  : registered one-cycle pulse on each accepted 0->1 transition
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE - 1);

  logic          btn_meta_q, btn_sync_q;
  logic          last_q;      // btn_sync level currently being timed
  logic          accepted_q;  // debounced level
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      last_q     <= 1'b0;
      accepted_q <= 1'b0;
      cnt_q      <= '0;
      press      <= 1'b0;
    end else begin
      btn_meta_q <= btn_in;
      btn_sync_q <= btn_meta_q;
      press      <= 1'b0;
      if (btn_sync_q != last_q) begin
        // Any change restarts the stability window.
        last_q <= btn_sync_q;
        cnt_q  <= '0;
      end else if (cnt_q != CntLast) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        accepted_q <= last_q;
        if (last_q && !accepted_q) begin
          press <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sum4bcc.sv
// 4-bit ripple-carry adder.
//   xi, yi : 4-bit operands
//   zi     : 4-bit sum
//   co     : carry out (sum > 15)
module sum4bcc (
  input  logic [3:0] xi,
  input  logic [3:0] yi,
  output logic [3:0] zi,
  output logic       co
);

  always_comb begin
    logic [4:0] c;
    c    = '0;
    zi   = '0;
    for (int i = 0; i < 4; i++) begin
      zi[i]  = xi[i] ^ yi[i] ^ c[i];
      c[i+1] = (xi[i] & yi[i]) | (c[i] & (xi[i] ^ yi[i]));
    end
    co = c[4];
  end

endmodule

// File: rtl/bcd_sum_display_ctrl.sv
// Operand capture / add / display sequencer for the 4-bit adder and 4-digit 7-segment display.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   sw      : operand switches (async)
//   btn     : load/advance button (async, bouncing)
//   seg     : [0:6] = a..g, active-low, registered
//   an      : digit anodes, active-low, registered, an[0] = rightmost
//   carryo  : registered carry of A+B
//   state_o : current FSM state
module bcd_sum_display_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEBOUNCE    = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [0:6] seg,
  output logic [3:0] an,
  output logic       carryo,
  output logic [1:0] state_o
);

  localparam int unsigned DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(REFRESH_DIV - 1);

  logic [3:0]    sw_meta_q, sw_sync_q;
  logic          press;
  state_e        state_q;
  logic [3:0]    a_q, b_q;
  logic [3:0]    zi;
  logic          co;
  logic [4:0]    sum5;
  logic [1:0]    tens;
  logic [3:0]    units;
  logic [DW-1:0] div_q;
  logic [1:0]    idx_q;
  logic [3:0]    dig_val;
  logic          dig_on;

  assign state_o = state_q;

  // Switch synchroniser
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  btn_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn),
    .press (press)
  );

  sum4bcc u_sum4bcc (
    .xi(a_q),
    .yi(b_q),
    .zi(zi),
    .co(co)
  );

  // Binary 0..30 to tens/units
  assign sum5 = {co, zi};

  always_comb begin
    tens  = 2'd0;
    units = sum5[3:0];
    if (sum5 >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(sum5 - 5'd30);
    end else if (sum5 >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(sum5 - 5'd20);
    end else if (sum5 >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(sum5 - 5'd10);
    end
  end

  // FSM and operand registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carryo  <= 1'b0;
    end else begin
      // Carry tracks the held operands; in the load states B is 0 so it stays low.
      carryo <= co;
      if (press) begin
        unique case (state_q)
          ST_IDLE: state_q <= ST_LOAD_A;
          ST_LOAD_A: begin
            a_q     <= sw_sync_q;
            state_q <= ST_LOAD_B;
          end
          ST_LOAD_B: begin
            b_q     <= sw_sync_q;
            state_q <= ST_SHOW;
          end
          ST_SHOW: begin
            a_q     <= '0;
            b_q     <= '0;
            carryo  <= 1'b0;
            state_q <= ST_LOAD_A;
          end
        endcase
      end
    end
  end

  // Scan divider and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Content of the digit currently selected by idx_q
  always_comb begin
    dig_val = '0;
    dig_on  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        dig_on = 1'b0;
      end
      ST_LOAD_A: begin
        if (idx_q == 2'd3) begin
          dig_on  = 1'b1;
          dig_val = sw_sync_q;
        end
      end
      ST_LOAD_B: begin
        if (idx_q == 2'd3) begin
          dig_on  = 1'b1;
          dig_val = a_q;
        end else if (idx_q == 2'd2) begin
          dig_on  = 1'b1;
          dig_val = sw_sync_q;
        end
      end
      ST_SHOW: begin
        dig_on = 1'b1;
        unique case (idx_q)
          2'd3: dig_val = a_q;
          2'd2: dig_val = b_q;
          2'd1: dig_val = {2'b00, tens};
          2'd0: dig_val = units;
        endcase
      end
    endcase
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
    end else if (dig_on) begin
      seg <= hex7seg(dig_val);
      an  <= ~(4'b0001 << idx_q);
    end else begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
    end
  end

endmodule
